// File: rtl/i2s_playback_serializer.sv
// I2S playback serializer: buffers AXI-stream stereo frames and shifts
// them MSB-first onto ac_pbdat, timed by the codec's bclk and pblrc.
`timescale 1ns/1ps
module i2s_playback_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          board_clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [2*DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          ac_bclk,
  input  logic                          ac_pblrc,
  output logic                          ac_pbdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int FW = 2 * DATA_WIDTH;
  localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LEFT,
    SHIFT,
    PAD
  } state_t;

  state_t state, state_d;

  logic bclk_s1, bclk_s2, bclk_q;
  logic lrc_s1, lrc_s2;
  logic bclk_rise, bclk_fall;
  logic lrc_prev, seeded;
  logic chan_start, start_left;

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          ready_ok;
  logic          push, pop, fifo_empty;

  logic [DATA_WIDTH-1:0] shreg, hold_right, load_word;
  logic [CW-1:0]         bit_cnt;
  logic                  load, shift, zero;

  always_ff @(posedge board_clk) begin
    if (reset) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_q  <= 1'b0;
      lrc_s1  <= 1'b0;
      lrc_s2  <= 1'b0;
    end else begin
      bclk_s1 <= ac_bclk;
      bclk_s2 <= bclk_s1;
      bclk_q  <= bclk_s2;
      lrc_s1  <= ac_pblrc;
      lrc_s2  <= lrc_s1;
    end
  end

  assign bclk_rise = bclk_s2 & ~bclk_q;
  assign bclk_fall = ~bclk_s2 & bclk_q;

  // A channel start armed on a rise is consumed (or dropped) at the next fall.
  always_ff @(posedge board_clk) begin
    if (reset) begin
      lrc_prev   <= 1'b0;
      seeded     <= 1'b0;
      chan_start <= 1'b0;
      start_left <= 1'b0;
    end else if (bclk_rise) begin
      lrc_prev <= lrc_s2;
      seeded   <= 1'b1;
      if (seeded && (lrc_s2 != lrc_prev)) begin
        chan_start <= 1'b1;
        start_left <= ~lrc_s2;
      end
    end else if (bclk_fall) begin
      chan_start <= 1'b0;
    end
  end

  always_ff @(posedge board_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    shift   = 1'b0;
    zero    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_d = WAIT_LEFT;
      end
      WAIT_LEFT: begin
        if (bclk_fall) begin
          if (!enable) begin
            state_d = IDLE;
            zero    = 1'b1;
          end else if (chan_start && start_left) begin
            state_d = SHIFT;
            load    = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bclk_fall) begin
          if (!enable) begin
            state_d = IDLE;
            zero    = 1'b1;
          end else if (chan_start) begin
            load = 1'b1;
          end else if (bit_cnt == LAST) begin
            state_d = PAD;
            zero    = 1'b1;
          end else begin
            shift = 1'b1;
          end
        end
      end
      PAD: begin
        if (bclk_fall) begin
          if (!enable) begin
            state_d = IDLE;
            zero    = 1'b1;
          end else if (chan_start) begin
            state_d = SHIFT;
            load    = 1'b1;
          end else begin
            zero = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_empty    = (level == '0);
  assign s_axis_tready = ready_ok && (level != FULL);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = load && start_left && !fifo_empty;
  assign fifo_level    = level;

  always_comb begin
    load_word = hold_right;
    if (start_left) begin
      load_word = '0;
      if (!fifo_empty) load_word = mem[rd_ptr][FW-1:DATA_WIDTH];
    end
  end

  always_ff @(posedge board_clk) begin
    if (push) mem[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_ok <= 1'b0;
    end else begin
      ready_ok <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Left start latches the right half so the later right slot needs no FIFO.
  always_ff @(posedge board_clk) begin
    if (reset) begin
      ac_pbdat        <= 1'b0;
      shreg           <= '0;
      hold_right      <= '0;
      bit_cnt         <= '0;
      underflow_count <= '0;
    end else if (load) begin
      ac_pbdat <= load_word[DATA_WIDTH-1];
      shreg    <= {load_word[DATA_WIDTH-2:0], 1'b0};
      bit_cnt  <= CW'(1);
      if (start_left) begin
        hold_right <= '0;
        if (!fifo_empty) begin
          hold_right <= mem[rd_ptr][DATA_WIDTH-1:0];
        end else if (underflow_count != 16'hFFFF) begin
          underflow_count <= underflow_count + 16'd1;
        end
      end
    end else if (shift) begin
      ac_pbdat <= shreg[DATA_WIDTH-1];
      shreg    <= {shreg[DATA_WIDTH-2:0], 1'b0};
      bit_cnt  <= bit_cnt + CW'(1);
    end else if (zero) begin
      ac_pbdat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_playback_serializer.sv
// Randomized bench for i2s_playback_serializer against a slot-level
// reference model of the codec-side bit stream and the frame queue.
`timescale 1ns/1ps
module tb_i2s_playback_serializer;

  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int FW    = 2 * DW;

  logic          board_clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [FW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          ac_bclk = 1'b1;
  logic          ac_pblrc = 1'b1;
  logic          ac_pbdat;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0]   underflow_count;

  int n_chk = 0;
  int n_err = 0;

  logic [FW-1:0] mq[$];
  logic [FW-1:0] sync_q[$];
  logic [DW-1:0] m_hold = '0;
  int            m_uf = 0;
  bit            m_active = 1'b0;
  bit            pend_left = 1'b0;
  int            slot_cnt = 0;

  bit            mon_valid = 1'b0;
  logic          mon_lrc = 1'b1;
  int            mon_k = 0;
  logic [DW-1:0] mon_word = '0;
  logic [DW-1:0] slot_exp = '0;
  logic          mon_pad = 1'b0;

  i2s_playback_serializer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .board_clk      (board_clk),
    .reset          (reset),
    .enable         (enable),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .ac_bclk        (ac_bclk),
    .ac_pblrc       (ac_pblrc),
    .ac_pbdat       (ac_pbdat),
    .fifo_level     (fifo_level),
    .underflow_count(underflow_count)
  );

  always #4 board_clk = ~board_clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] rnd_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  task automatic finish_slot();
    check(mon_lrc ? "right" : "left", 64'(mon_word), 64'(slot_exp));
    check("pad", 64'(mon_pad), 64'(0));
    check("uf", 64'(underflow_count), 64'(m_uf));
    check("lvl", 64'(fifo_level), 64'(mq.size()));
  endtask

  task automatic mon_sample();
    if (ac_pblrc != mon_lrc) begin
      if (mon_valid) finish_slot();
      mon_valid = 1'b1;
      mon_lrc   = ac_pblrc;
      mon_k     = 0;
      mon_word  = '0;
      mon_pad   = ac_pbdat;
      if (ac_pblrc) begin
        slot_exp = m_active ? m_hold : '0;
      end else begin
        slot_exp  = '0;
        pend_left = 1'b1;
      end
    end else begin
      mon_k++;
      if (mon_k <= DW) mon_word = {mon_word[DW-2:0], ac_pbdat};
      else             mon_pad  = mon_pad | ac_pbdat;
    end
  endtask

  task automatic left_load();
    logic [FW-1:0] f;
    m_active = 1'b1;
    if (mq.size() > 0) begin
      f = mq.pop_front();
    end else begin
      f = '0;
      if (m_uf < 65535) m_uf++;
    end
    slot_exp = f[FW-1:DW];
    m_hold   = f[DW-1:0];
  endtask

  task automatic push_frame(input logic [FW-1:0] f);
    bit exp_acc;
    exp_acc       = (mq.size() < DEPTH);
    s_axis_tdata  = f;
    s_axis_tvalid = 1'b1;
    check("tready", 64'(s_axis_tready), 64'(exp_acc));
    @(negedge board_clk);
    s_axis_tvalid = 1'b0;
    if (exp_acc) mq.push_back(f);
  endtask

  // One 80 ns bclk period; pblrc flips on the falling edge every 32 bclk.
  task automatic bclk_cycle();
    bit            do_load;
    bit            exp_acc;
    logic [FW-1:0] pf;
    @(negedge board_clk);
    ac_bclk = 1'b0;
    if (slot_cnt == 31) begin
      ac_pblrc = ~ac_pblrc;
      slot_cnt = 0;
    end else begin
      slot_cnt++;
    end
    do_load   = pend_left && enable;
    pend_left = 1'b0;
    if (do_load) left_load();
    if (do_load && sync_q.size() > 0) begin
      pf      = sync_q.pop_front();
      exp_acc = (mq.size() < DEPTH);
      repeat (2) @(negedge board_clk);
      s_axis_tdata  = pf;
      s_axis_tvalid = 1'b1;
      check("pp_rdy", 64'(s_axis_tready), 64'(exp_acc));
      @(negedge board_clk);
      s_axis_tvalid = 1'b0;
      if (exp_acc) mq.push_back(pf);
      check("pp_lvl", 64'(fifo_level), 64'(mq.size()));
      repeat (2) @(negedge board_clk);
    end else begin
      repeat (5) @(negedge board_clk);
    end
    ac_bclk = 1'b1;
    mon_sample();
    repeat (4) @(negedge board_clk);
  endtask

  task automatic run_bclk(input int n);
    for (int i = 0; i < n; i++) bclk_cycle();
  endtask

  task automatic model_reset();
    mq.delete();
    sync_q.delete();
    m_uf      = 0;
    m_hold    = '0;
    m_active  = 1'b0;
    pend_left = 1'b0;
    mon_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    // Reset state
    repeat (3) @(negedge board_clk);
    check("rst_dat", 64'(ac_pbdat), 64'(0));
    check("rst_lvl", 64'(fifo_level), 64'(0));
    check("rst_rdy", 64'(s_axis_tready), 64'(0));
    check("rst_uf", 64'(underflow_count), 64'(0));
    reset = 1'b0;
    @(negedge board_clk);
    check("rdy_up", 64'(s_axis_tready), 64'(1));

    // Fill the FIFO with bclk stopped; the fifth frame must be refused
    push_frame(48'hABCDEF_123456);
    for (int i = 0; i < 4; i++) push_frame(rnd_frame());
    check("full_lvl", 64'(fifo_level), 64'(DEPTH));
    check("full_rdy", 64'(s_axis_tready), 64'(0));

    // Normal playback, then run dry into underflow
    enable = 1'b1;
    run_bclk(33);
    check("pop1_lvl", 64'(fifo_level), 64'(mq.size()));
    check("pop1_rdy", 64'(s_axis_tready), 64'(mq.size() < DEPTH));
    run_bclk(64 * 6);

    // Push aligned with each left pop at level 2, eight frames across wrap
    push_frame(rnd_frame());
    push_frame(rnd_frame());
    for (int i = 0; i < 6; i++) sync_q.push_back(rnd_frame());
    run_bclk(64 * 9);
    check("pp_done", 64'(sync_q.size()), 64'(0));

    // Drop enable mid left word
    push_frame({FW{1'b1}});
    push_frame({FW{1'b1}});
    for (guard = 0; guard < 300; guard++) begin
      if (m_active && !ac_pblrc && slot_cnt == 10 && mq.size() == 1) break;
      bclk_cycle();
    end
    check("dis_wait", 64'(guard < 300), 64'(1));
    check("dis_pre", 64'(ac_pbdat), 64'(1));
    enable    = 1'b0;
    m_active  = 1'b0;
    mon_valid = 1'b0;
    bclk_cycle();
    check("dis_dat", 64'(ac_pbdat), 64'(0));
    run_bclk(64 * 3);
    check("dis_uf", 64'(underflow_count), 64'(m_uf));
    check("dis_lvl", 64'(fifo_level), 64'(1));

    // Reset mid left word, then restart only on a full left transition
    enable = 1'b1;
    for (guard = 0; guard < 300; guard++) begin
      if (m_active && !ac_pblrc && slot_cnt == 5) break;
      bclk_cycle();
    end
    check("rst_wait", 64'(guard < 300), 64'(1));
    check("rst_pre", 64'(ac_pbdat), 64'(1));
    reset = 1'b1;
    @(negedge board_clk);
    check("mid_dat", 64'(ac_pbdat), 64'(0));
    check("mid_lvl", 64'(fifo_level), 64'(0));
    check("mid_rdy", 64'(s_axis_tready), 64'(0));
    check("mid_uf", 64'(underflow_count), 64'(0));
    reset = 1'b0;
    model_reset();
    @(negedge board_clk);
    check("mid_up", 64'(s_axis_tready), 64'(1));
    push_frame(rnd_frame());
    run_bclk(64 * 3);

    // Saturating underflow counter
    force dut.underflow_count = 16'hFFFF;
    @(negedge board_clk);
    release dut.underflow_count;
    m_uf = 65535;
    @(negedge board_clk);
    check("sat_pre", 64'(underflow_count), 64'(16'hFFFF));
    run_bclk(64 * 2);
    check("sat", 64'(underflow_count), 64'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
